// File: rtl/asm_inv_if.sv
// Request/response bundle for the asm_inv sequence decoder.
// The requester drives start/din; the decoder returns dout/err/done_tick/busy.
interface asm_inv_if #(
  parameter int unsigned DW = 7,
  parameter int unsigned NW = 5
);
  logic          start;
  logic [DW-1:0] din;
  logic [NW-1:0] dout;
  logic          err;
  logic          done_tick;
  logic          busy;

  modport master (
    output start,
    output din,
    input  dout,
    input  err,
    input  done_tick,
    input  busy
  );

  modport slave (
    input  start,
    input  din,
    output dout,
    output err,
    output done_tick,
    output busy
  );
endinterface

// File: rtl/asm_inv.sv
// Iterative decoder for y = BASE + STEP*n: recovers n by repeated subtraction and
// flags values that are not members of the sequence.
module asm_inv #(
  parameter int unsigned DW   = 7,
  parameter int unsigned NW   = 5,
  parameter int unsigned BASE = 1,
  parameter int unsigned STEP = 5
) (
  input  logic   clk,
  input  logic   reset,
  asm_inv_if.slave bus
);

  localparam logic [DW-1:0] BaseW  = DW'(BASE);
  localparam logic [DW-1:0] StepW  = DW'(STEP);
  localparam logic [DW-1:0] LimitW = DW'(BASE + STEP);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOp   = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] r_q, r_d;
  logic [NW-1:0] n_q, n_d;
  logic          e_q, e_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      r_q     <= '0;
      n_q     <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      n_q     <= n_d;
      e_q     <= e_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    n_d     = n_q;
    e_d     = e_q;
    case (state_q)
      StIdle: begin
        n_d = '0;
        e_d = 1'b0;
        if (bus.start) begin
          if (bus.din == '0) begin
            // Zero can never be a member; skip op entirely.
            r_d     = '0;
            e_d     = 1'b1;
            state_d = StDone;
          end else begin
            r_d     = bus.din;
            state_d = StOp;
          end
        end
      end
      StOp: begin
        if (r_q == BaseW) begin
          e_d     = 1'b0;
          state_d = StDone;
        end else if (r_q < LimitW) begin
          // Remainder fell off the sequence; partial count is discarded.
          e_d     = 1'b1;
          n_d     = '0;
          state_d = StDone;
        end else begin
          r_d = r_q - StepW;
          n_d = n_q + NW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.done_tick = (state_q == StDone);
    bus.dout      = (state_q == StDone) ? n_q : '0;
    bus.err       = (state_q == StDone) ? e_q : 1'b0;
    bus.busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_asm_inv.sv
// Directed bench for asm_inv: vector table of decode results and latencies,
// plus reset-abort and back-to-back sequences.
module tb_asm_inv;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  asm_inv_if #(.DW(7), .NW(5)) bus ();

  asm_inv #(
    .DW  (7),
    .NW  (5),
    .BASE(1),
    .STEP(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] din;
    logic [4:0] dout;
    logic       err;
    int         lat;
    bit         noise;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Launch one request and watch it for its expected latency plus two cycles.
  task automatic run(input vec_t v, input string tag);
    int         pulses;
    int         bad_done;
    int         bad_busy;
    int         bad_zero;
    logic [4:0] got_dout;
    logic       got_err;
    pulses   = 0;
    bad_done = 0;
    bad_busy = 0;
    bad_zero = 0;
    got_dout = 5'h1f;
    got_err  = 1'bx;
    bus.din   = v.din;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= v.lat + 2; c++) begin
      if (bus.done_tick === 1'b1) pulses++;
      if (bus.done_tick !== (c == v.lat)) bad_done++;
      if (bus.busy !== (c <= v.lat)) bad_busy++;
      if (c == v.lat) begin
        got_dout = bus.dout;
        got_err  = bus.err;
      end else if (bus.dout !== 5'd0 || bus.err !== 1'b0) begin
        bad_zero++;
      end
      // Requests during op/done must be ignored, including one in the done cycle.
      if (v.noise && c <= v.lat) begin
        bus.start = c[0];
        bus.din   = 7'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check({tag, " dout"}, int'(got_dout), int'(v.dout));
    check({tag, " err"}, int'(got_err), int'(v.err));
    check({tag, " done_timing"}, bad_done, 0);
    check({tag, " pulses"}, pulses, 1);
    check({tag, " busy"}, bad_busy, 0);
    check({tag, " outputs_zero_else"}, bad_zero, 0);
  endtask

  initial begin
    int seen;
    total = 0;
    bad   = 0;

    //          din      dout   err   lat  noise
    vecs[0]  = '{7'd1,   5'd0,  1'b0, 2,   1'b0};
    vecs[1]  = '{7'd76,  5'd15, 1'b0, 17,  1'b0};
    vecs[2]  = '{7'd126, 5'd25, 1'b0, 27,  1'b0};
    vecs[3]  = '{7'd127, 5'd0,  1'b1, 27,  1'b0};
    vecs[4]  = '{7'd3,   5'd0,  1'b1, 2,   1'b0};
    vecs[5]  = '{7'd0,   5'd0,  1'b1, 1,   1'b0};
    vecs[6]  = '{7'd11,  5'd2,  1'b0, 4,   1'b0};
    vecs[7]  = '{7'd6,   5'd1,  1'b0, 3,   1'b0};
    vecs[8]  = '{7'd5,   5'd0,  1'b1, 2,   1'b0};
    vecs[9]  = '{7'd76,  5'd15, 1'b0, 17,  1'b1};
    vecs[10] = '{7'd0,   5'd0,  1'b1, 1,   1'b1};
    vecs[11] = '{7'd16,  5'd3,  1'b0, 5,   1'b1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.din   = '0;
    #2;
    check("reset done_tick", int'(bus.done_tick), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset dout", int'(bus.dout), 0);
    check("reset err", int'(bus.err), 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run(vecs[i], $sformatf("vec%0d_din%0d", i, vecs[i].din));
    end

    // Abort a din=76 run in op cycle 5.
    bus.din   = 7'd76;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    check("abort busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check("abort busy", int'(bus.busy), 0);
    check("abort done_tick", int'(bus.done_tick), 0);
    check("abort dout", int'(bus.dout), 0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done_tick === 1'b1 || bus.busy === 1'b1) seen++;
      tick();
    end
    check("abort no_activity", seen, 0);
    run('{7'd11, 5'd2, 1'b0, 4, 1'b0}, "post_abort_din11");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
